i2c_eeprom_24lc04: RTL and testbench
====================================

// Module: i2c_eeprom_24lc04
// PURPOSE
//  Clocked, synthesizable I2C slave emulating a 24LC04B 4-Kbit serial EEPROM:
//  512 bytes organised as 2 blocks of 256 bytes.
//  Serves as the on-board or bench target for the command-bridge I2C master.
//  Oversamples SCL/SDA on clk and drives SDA open-drain.
// PARAMETERS
//  TWC_CYCLES    50000   write-cycle busy time in clk cycles (5 ms at 10 MHz equivalent)
//  PRELOAD_ADDR  9'h020  array location preset at power-up
//  PRELOAD_DATA  8'hAB   value preset at PRELOAD_ADDR; all other bytes power up as 8'hFF
// PORTS
//  clk    in     1  system clock, >= 16x SCL frequency
//  rst_n  in     1  reset, asynchronous, active-high
//  A0     in     1  chip-select pin; unused, as on the 24LC04B
//  A1     in     1  chip-select pin; unused, as on the 24LC04B
//  A2     in     1  chip-select pin; unused, as on the 24LC04B
//  WP     in     1  write protect, 1 = array read-only
//  SCL    in     1  I2C clock (external pull-up)
//  SDA    inout  1  I2C data, open-drain: drives 1'b0 or 1'bz only
// BEHAVIOUR
//  Reset: rst_n is asynchronous, active-high.
//   - SDA released (z); FSM to IDLE; address pointer = 0; busy cleared.
//   - Array contents are kept.
//  Input sampling:
//   - SCL and SDA pass through 2-flop synchronisers.
//   - Edges are detected on the synchronised copies.
//  Bus conditions:
//   - START = SDA falls while SCL high.
//   - STOP = SDA rises while SCL high.
//   - Both are honoured in any state; START means restart.
//   - Data bits are sampled on SCL rise.
//   - SDA output changes only <= 3 clk after an SCL fall.
//  Byte framing:
//   - Bits are MSB first.
//   - ACK = SDA driven low from the SCL fall after bit 8 until the SCL fall after bit 9.
//  FSM states: IDLE, CTRL, ACK_CTRL, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, MACK, BUSY.
//   - IDLE, on START -> CTRL: shift in 8 bits.
//   - Control byte [7:4] must be 4'b1010. Bits [3:2] are don't-care. Bit [1] = B0, the block bit. Bit [0] = R/W.
//   - Mismatch -> no ACK, go to IDLE.
//   - Match, R/W=0 -> ACK, then WADDR; pointer[8] = B0.
//   - Match, R/W=1 -> ACK, then RDATA; current-address read.
//   - WADDR: shift 8 bits into pointer[7:0], ACK -> WDATA.
//   - WDATA: each byte ACKed and stored in a 16-byte page buffer at pointer[3:0].
//     - pointer[3:0] increments and wraps inside the page; pointer[8:4] is fixed.
//     - More than 16 bytes overwrite earlier buffer entries.
//   - STOP in WDATA after >= 1 data byte:
//     - WP=0: buffered bytes are copied into the array, 1 per clk.
//     - WP=0: enter BUSY for TWC_CYCLES clk.
//     - WP=1: discard the buffer, go to IDLE.
//   - STOP or START right after WADDR: no write; pointer retained. This is the random-read setup.
//   - BUSY: the device NACKs every control byte (ack polling).
//     - At the end of BUSY -> IDLE.
//     - A START during BUSY is tracked only to NACK.
//   - RDATA: drive mem[pointer] bit-by-bit (0 bits = drive low, 1 bits = release).
//     - pointer increments by 1 after each byte; 9'h1FF wraps to 9'h000.
//   - MACK: master ACK -> next RDATA byte.
//   - MACK: master NACK -> release SDA, go to IDLE and await STOP.
//  Arithmetic:
//   - pointer is 9 bits and wraps modulo 512.
//   - Page index is pointer[3:0], modulo 16.
//  Reset mid-transaction:
//   - Aborts immediately; any uncopied buffer bytes are lost.
//   - Bytes already copied remain in the array.
// TESTING
//  - Power-up random read: write ctrl A0, waddr 20, Sr, ctrl A1 -> byte AB, master NACK, STOP.
//  - Write/readback: A0,10,DE,STOP; poll until ACK; random read 10 -> DE.
//    - Each byte ACKed.
//    - A0 during BUSY -> NACK.
//  - Page wrap: A2,00, then 18 bytes 00..11 -> block1 bytes 00,01 = 10,11; bytes 02..0F = 02..0F.
//  - WP=1: A0,30,55,STOP -> all ACKed, no BUSY; read 30 -> FF.
//  - Bad control byte 90 -> SDA stays high on the 9th clock; FSM returns to IDLE.
//  - Sequential read from 1FF with ACK: bytes mem[1FF], mem[000] (wrap).
//  - Reset mid-read: SDA released within 1 clk of rst_n assertion.

Source files
------------

// File: rtl/i2c_eeprom_24lc04.sv
// i2c_eeprom_24lc04
//   I2C slave that behaves like a 24LC04B serial EEPROM. It holds 512 bytes in
//   two 256-byte blocks. SCL and SDA are oversampled on clk, and SDA is driven
//   open-drain.
// Ports
//   clk    in     system clock, at least 16x the SCL frequency
//   rst_n  in     asynchronous reset, active-high. The array contents survive it.
//   A0..A2 in     chip-select pins, ignored as on the real part
//   WP     in     write protect; 1 keeps the array read-only
//   SCL    in     I2C clock
//   SDA    inout  I2C data; the device drives only 1'b0 or 1'bz
module i2c_eeprom_24lc04 #(
  parameter int unsigned TWC_CYCLES   = 50000,
  parameter logic [8:0]  PRELOAD_ADDR = 9'h020,
  parameter logic [7:0]  PRELOAD_DATA = 8'hAB
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic WP,
  input  logic SCL,
  inout  wire  SDA
);

  localparam int          CW       = $clog2(TWC_CYCLES);
  localparam logic [31:0] COLD_SIG = 32'h24C0_4B1E;

  typedef enum logic [3:0] {
    IDLE, CTRL, ACK_CTRL, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, MACK, BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [8:0]      ptr_q, ptr_d;
  logic            sda_oe_q, sda_oe_d;
  logic            rw_q, rw_d;
  logic            nack_q, nack_d;
  logic [15:0]     valid_q, valid_d;
  logic [CW-1:0]   busy_cnt_q, busy_cnt_d;
  logic [8:0]      init_cnt_q;
  logic [31:0]     sig_q;
  logic [2:0]      scl_sync_q, sda_sync_q;
  logic [7:0]      mem_q [512];
  logic [7:0]      buf_q [16];
  logic            buf_we;

  logic unused_pins;
  assign unused_pins = A0 ^ A1 ^ A2;

  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  // Stages [1:0] synchronise the pins; stage [2] holds the previous value for edge detection.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], SCL};
      sda_sync_q <= {sda_sync_q[1:0], SDA};
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond, byte_done;
  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise   = scl_s & ~scl_sync_q[2];
  assign scl_fall   = ~scl_s & scl_sync_q[2];
  assign start_cond = scl_s & scl_sync_q[2] & sda_sync_q[2] & ~sda_s;
  assign stop_cond  = scl_s & scl_sync_q[2] & ~sda_sync_q[2] & sda_s;
  assign byte_done  = scl_fall && (bit_cnt_q == 4'd8);

  // The array has no reset, so a power-up fill is needed. A signature register
  // marks a cold start. Until the signature matches, one byte per clk is
  // written with the preset image. Later resets find the signature intact and
  // leave the array alone.
  logic init_busy;
  assign init_busy = (sig_q != COLD_SIG);

  // The first 16 BUSY cycles copy the valid page-buffer entries into the array.
  logic [3:0] copy_idx;
  logic       copy_en;
  assign copy_idx = busy_cnt_q[3:0];
  assign copy_en  = (state_q == BUSY) && (busy_cnt_q < CW'(16));

  logic [7:0] rd_byte;
  assign rd_byte = mem_q[ptr_q];

  // NOTE: storage arrays are deliberately left out of reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem_q[init_cnt_q] <= (init_cnt_q == PRELOAD_ADDR) ? PRELOAD_DATA : 8'hFF;
    end else if (copy_en && valid_q[copy_idx]) begin
      mem_q[{ptr_q[8:4], copy_idx}] <= buf_q[copy_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy && (init_cnt_q == 9'h1FF)) sig_q <= COLD_SIG;
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[ptr_q[3:0]] <= shift_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      valid_q    <= '0;
      busy_cnt_q <= '0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
      if (init_busy) init_cnt_q <= init_cnt_q + 9'd1;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q, so no path through this block infers a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    nack_d     = nack_q;
    valid_d    = valid_q;
    busy_cnt_d = busy_cnt_q;
    buf_we     = 1'b0;

    unique case (state_q)
      CTRL, WADDR, WDATA: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (byte_done) begin
          sda_oe_d = 1'b1;
          if (state_q == CTRL) begin
            if (shift_q[7:4] == 4'b1010) begin
              rw_d = shift_q[0];
              if (!shift_q[0]) ptr_d[8] = shift_q[1];
              state_d = ACK_CTRL;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IDLE;
            end
          end else if (state_q == WADDR) begin
            ptr_d[7:0] = shift_q;
            state_d    = ACK_WADDR;
          end else begin
            buf_we                = 1'b1;
            valid_d[ptr_q[3:0]]   = 1'b1;
            ptr_d[3:0]            = ptr_q[3:0] + 4'd1;  // wraps inside the page
            state_d               = ACK_WDATA;
          end
        end
      end
      ACK_CTRL, ACK_WADDR, ACK_WDATA: begin
        if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
          if (state_q == ACK_CTRL && rw_q) begin
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d  = RDATA;
          end else if (state_q == ACK_CTRL) begin
            state_d = WADDR;
          end else begin
            if (state_q == ACK_WADDR) valid_d = '0;
            state_d = WDATA;
          end
        end
      end
      RDATA: begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 9'd1;
            state_d  = MACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      MACK: begin
        if (scl_rise) begin
          nack_d = sda_s;
        end else if (scl_fall) begin
          bit_cnt_d = '0;
          if (nack_q) begin
            state_d = IDLE;
          end else begin
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            state_d  = RDATA;
          end
        end
      end
      BUSY: begin
        busy_cnt_d = busy_cnt_q + 1'b1;
        if (busy_cnt_q == CW'(TWC_CYCLES - 1)) state_d = IDLE;
      end
      default: ;
    endcase

    // Bus conditions override the per-state decode. While BUSY the device
    // never drives SDA, so every control byte is left unacknowledged.
    if (start_cond && !init_busy && state_q != BUSY) begin
      state_d   = CTRL;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_cond && state_q != BUSY) begin
      sda_oe_d = 1'b0;
      if (state_q == WDATA && |valid_q && !WP) begin
        state_d    = BUSY;
        busy_cnt_d = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_24lc04.sv
// tb_i2c_eeprom_24lc04
//   Bit-banged I2C master driving the 24LC04B emulation. A byte-array model
//   with an address pointer supplies every expected value. TWC_CYCLES is
//   shortened so write cycles stay short.
module tb_i2c_eeprom_24lc04;

  localparam int TWC = 400;
  localparam int Q   = 50;  // quarter SCL period in ns (5 clk)

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
  logic wp = 1'b0;
  logic scl = 1'b1;
  logic m_sda_oe = 1'b0;
  wire  sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_eeprom_24lc04 #(.TWC_CYCLES(TWC)) dut (
    .clk(clk), .rst_n(rst_n), .A0(a0), .A1(a1), .A2(a2),
    .WP(wp), .SCL(scl), .SDA(sda_bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [512];
  logic [8:0] model_ptr;
  logic [7:0] wq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read();
    logic [7:0] v;
    v = model_mem[model_ptr];
    model_ptr = model_ptr + 9'd1;
    return v;
  endfunction

  function automatic logic [7:0] ctrl(input logic blk, input logic rd);
    return {4'b1010, 2'b00, blk, rd};
  endfunction

  task automatic bus_start();
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1; #(2*Q);
    m_sda_oe = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda_oe = 1'b1; #Q;
    scl = 1'b1; #(2*Q);
    m_sda_oe = 1'b0; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda_oe = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic get_byte(input logic master_ack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~master_ack);
  endtask

  task automatic random_read_setup(input logic [8:0] addr, output logic ok);
    logic k1, k2, k3;
    bus_start();
    put_byte(ctrl(addr[8], 1'b0), k1);
    put_byte(addr[7:0], k2);
    bus_start();
    put_byte(ctrl(addr[8], 1'b1), k3);
    ok = k1 & k2 & k3;
    model_ptr = addr;
  endtask

  // Page write of wq at addr followed by STOP; the model applies the page-wrap rule.
  task automatic write_tx(input logic [8:0] addr, output int nacks);
    logic k;
    nacks = 0;
    bus_start();
    put_byte(ctrl(addr[8], 1'b0), k); if (!k) nacks++;
    put_byte(addr[7:0], k);           if (!k) nacks++;
    foreach (wq[i]) begin
      put_byte(wq[i], k);
      if (!k) nacks++;
    end
    bus_stop();
    foreach (wq[i]) if (!wp) model_mem[{addr[8:4], 4'(addr[3:0] + i)}] = wq[i];
    model_ptr = {addr[8:4], 4'(addr[3:0] + wq.size())};
  endtask

  task automatic poll(output logic ok);
    int polls;
    ok = 1'b0;
    polls = 0;
    while (!ok && polls < 40) begin
      bus_start();
      put_byte(8'hA0, ok);
      bus_stop();
      polls++;
    end
    if (ok) model_ptr[8] = 1'b0;
  endtask

  logic       ok;
  logic [7:0] d;
  int         n;
  logic [8:0] ra;
  int         rn;

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = 8'hFF;
    model_mem[9'h020] = 8'hAB;
    model_ptr = '0;

    repeat (4) @(negedge clk);
    check("reset_sda_released", sda_bus, 1);
    rst_n = 1'b0;
    repeat (600) @(negedge clk);

    // Power-up random read of the preset byte
    random_read_setup(9'h020, ok);
    check("pwr_ctrl_acks", ok, 1);
    get_byte(1'b0, d);
    bus_stop();
    check("pwr_read_020", d, model_read());

    // Single-byte write, busy NACK, polling, readback
    wq = {8'hDE};
    write_tx(9'h010, n);
    check("wr_nacks", n, 0);
    bus_start(); put_byte(8'hA0, ok); bus_stop();
    check("busy_poll_nack", ok, 0);
    poll(ok);
    check("poll_ack", ok, 1);
    random_read_setup(9'h010, ok);
    check("rd010_acks", ok, 1);
    get_byte(1'b0, d);
    bus_stop();
    check("readback_010", d, model_read());

    // 18 bytes into block 1 page 0: the last two wrap onto entries 0 and 1
    wq.delete();
    for (int i = 0; i < 18; i++) wq.push_back(8'(i));
    write_tx(9'h100, n);
    check("page_nacks", n, 0);
    poll(ok);
    check("page_poll_ack", ok, 1);
    random_read_setup(9'h100, ok);
    check("page_rd_acks", ok, 1);
    for (int i = 0; i < 16; i++) begin
      get_byte(i != 15, d);
      check($sformatf("page_rd_%0d", i), d, model_read());
    end
    bus_stop();

    // Write-protected write is acknowledged but never reaches the array
    wp = 1'b1;
    wq = {8'h55};
    write_tx(9'h030, n);
    check("wp_nacks", n, 0);
    bus_start(); put_byte(8'hA0, ok); bus_stop();
    check("wp_no_busy", ok, 1);
    wp = 1'b0;
    random_read_setup(9'h030, ok);
    get_byte(1'b0, d);
    bus_stop();
    check("wp_read_030", d, model_read());

    // Wrong device code is not acknowledged; the device still responds afterwards
    bus_start(); put_byte(8'h90, ok); bus_stop();
    check("bad_ctrl_nack", ok, 0);
    random_read_setup(9'h020, ok);
    get_byte(1'b0, d);
    bus_stop();
    check("after_bad_ctrl", d, model_read());

    // Distinct values at 1FF and 000, then a sequential read across the wrap
    wq = {8'h5A};
    write_tx(9'h1FF, n);
    poll(ok);
    wq = {8'hA5};
    write_tx(9'h000, n);
    poll(ok);
    check("wrap_prep_poll", ok, 1);
    random_read_setup(9'h1FF, ok);
    check("wrap_rd_acks", ok, 1);
    get_byte(1'b1, d);
    check("seq_rd_1ff", d, model_read());
    get_byte(1'b0, d);
    check("seq_rd_000", d, model_read());
    bus_stop();

    // Reset while the device is driving the ACK of a read control byte
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(ctrl(1'b0, 1'b1)[i]);
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    check("ack_low_before_reset", sda_bus, 0);
    rst_n = 1'b1; #10;
    check("sda_release_on_reset", sda_bus, 1);
    scl = 1'b0; #Q;
    rst_n = 1'b0; #(4*Q);
    bus_stop();
    model_ptr = '0;
    bus_start();
    put_byte(ctrl(1'b0, 1'b1), ok);
    get_byte(1'b0, d);
    bus_stop();
    check("post_reset_cur_ack", ok, 1);
    check("post_reset_cur_rd", d, model_read());
    random_read_setup(9'h010, ok);
    get_byte(1'b0, d);
    bus_stop();
    check("array_kept_010", d, model_read());

    // Randomised page writes, some write-protected, each read back as a full page
    for (int t = 0; t < 5; t++) begin
      ra = 9'($urandom_range(0, 511));
      rn = $urandom_range(1, 20);
      wp = ($urandom_range(0, 3) == 0);
      wq.delete();
      for (int i = 0; i < rn; i++) wq.push_back(8'($urandom));
      write_tx(ra, n);
      check($sformatf("rnd%0d_nacks", t), n, 0);
      bus_start(); put_byte(8'hA0, ok); bus_stop();
      if (wp) begin
        check($sformatf("rnd%0d_wp_no_busy", t), ok, 1);
      end else begin
        check($sformatf("rnd%0d_busy_nack", t), ok, 0);
        poll(ok);
        check($sformatf("rnd%0d_poll", t), ok, 1);
      end
      wp = 1'b0;
      random_read_setup({ra[8:4], 4'h0}, ok);
      check($sformatf("rnd%0d_rd_acks", t), ok, 1);
      for (int i = 0; i < 16; i++) begin
        get_byte(i != 15, d);
        check($sformatf("rnd%0d_rd_%0d", t, i), d, model_read());
      end
      bus_stop();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
